lane_route_controller: RTL and testbench
========================================

Name: lane_route_controller

Overview:
Sequencer for a bank of NUM_LANES data lanes (row or column routers).
- Fill: clears the lanes, loads each lane's start/end element address, then streams scratchpad words so every lane captures its slice into its MISO FIFO.
- Stream: pops all lanes in lockstep toward the PE array, optionally replaying the buffered tile via FIFO read-pointer reset.
- Sits between the tile-level control FSM and the data_lane instances.

Parameters:
NUM_LANES, 4, number of data lanes driven
ADDR_WIDTH, 8, element and word address width
CNT_WIDTH, 8, width of stream-length and reuse counters

Ports:
i_clk  in  1  clock
i_nrst  in  1  synchronous active-low reset
i_start  in  1  start pulse; sampled in IDLE only
i_base_addr  in  ADDR_WIDTH  element address of lane 0 start
i_lane_stride  in  ADDR_WIDTH  elements per lane (also stream length)
i_first_word  in  ADDR_WIDTH  first scratchpad word to read
i_word_limit  in  ADDR_WIDTH  last word allowed before timeout error
i_reuse  in  CNT_WIDTH  extra stream replays (0 = stream once)
i_pop_ready  in  1  PE array accepts a pop this cycle
i_lane_route_done  in  NUM_LANES  per-lane route done
i_lane_miso_full  in  NUM_LANES  per-lane full / not-enough-slots
o_reg_clear  out  1  lane register clear
o_addr_write_en  out  1  lane address load strobe
o_lane_start_addr  out  NUM_LANES*ADDR_WIDTH  lane k = base + k*stride
o_lane_end_addr  out  NUM_LANES*ADDR_WIDTH  lane k = base + (k+1)*stride
o_spad_rd_en  out  1  scratchpad read request
o_spad_addr  out  ADDR_WIDTH  scratchpad word address
o_lane_addr  out  ADDR_WIDTH  word address aligned to returned data (o_spad_addr delayed 1)
o_data_valid  out  1  o_spad_rd_en delayed 1 cycle
o_ac_en  out  1  lane accept enable
o_miso_pop_en  out  1  lockstep pop to all lanes
o_fifo_ptr_reset  out  1  read-pointer rewind pulse
o_busy  out  1  not IDLE
o_done  out  1  one-cycle completion pulse
o_error  out  1  sticky overflow/timeout flag, cleared by next i_start

Behaviour:
- Reset (i_nrst=0 at posedge): state IDLE; all outputs 0; all counters 0. Reset mid-operation aborts immediately with no done pulse.
- Address arithmetic: computed in ADDR_WIDTH, modulo 2^ADDR_WIDTH, from config registered at i_start. Outputs are held until the next i_start.
- States: IDLE -> CLEAR -> CONFIG -> ROUTE -> FLUSH -> STREAM -> (REWIND -> STREAM)* -> DONE -> IDLE.
- IDLE: on i_start, register all config inputs, clear o_error, go to CLEAR. i_start in any other state is ignored.
- CLEAR (1 cycle): o_reg_clear=1.
- CONFIG (1 cycle): o_addr_write_en=1. Address outputs are already valid this cycle.
- ROUTE:
  - o_ac_en=1; o_spad_rd_en=1 every cycle.
  - o_spad_addr starts at i_first_word and increments by 1 per cycle.
  - o_lane_addr and o_data_valid are registered copies of o_spad_addr and o_spad_rd_en (1-cycle scratchpad latency).
  - Exit to FLUSH when i_lane_route_done is all-ones.
  - If o_spad_addr would exceed i_word_limit while not all done: set o_error and go to DONE.
- Overflow: any i_lane_miso_full bit high in ROUTE or FLUSH while o_data_valid=1 sets o_error and goes to DONE. The tile must fit the FIFOs.
- FLUSH (1 cycle):
  - o_spad_rd_en=0; o_ac_en stays 1 so the last in-flight beat is accepted.
  - Extra beats read after route_done carry no hits and are harmless.
- STREAM:
  - o_miso_pop_en = i_pop_ready. Pop counter increments on each pop.
  - At i_lane_stride pops: if replays done < i_reuse go to REWIND, else go to DONE.
  - i_lane_stride=0: STREAM exits immediately with zero pops.
- REWIND (1 cycle): o_fifo_ptr_reset=1; pop counter cleared; replay counter incremented.
- DONE (1 cycle): o_done=1; then IDLE.
- o_busy=1 in every state except IDLE. o_ac_en is 0 outside ROUTE/FLUSH.

Test Plan:
- Basic fill/stream: base=0, stride=8, NUM_LANES=4, first_word=0, route_done asserted after word 3, i_pop_ready=1.
  - Required: clear at cycle 1, addr_write_en at cycle 2, reads of words 0..3(+1 in flight), exactly 8 pops, o_done pulse, o_error=0.
- Address outputs: base=5, stride=3.
  - Required: lane start/end = 5/8, 8/11, 11/14, 14/17.
- Backpressure: i_pop_ready toggles 1,0,1,0.
  - Required: pops only on ready cycles, total still 8, done after the 8th pop.
- Reuse: i_reuse=2, stride=4.
  - Required: 12 pops in three groups of 4, o_fifo_ptr_reset pulsed exactly twice between groups.
- Error paths:
  - Lane 2 miso_full with data_valid in ROUTE: o_error=1, no pops, done pulse.
  - word_limit=2 with route_done never asserted: o_error=1 after word 2.
- Reset mid-STREAM: i_nrst=0 for one cycle.
  - Required: next cycle all outputs 0, state IDLE, no done pulse; a new i_start runs normally.

Source files
------------

// File: rtl/lane_route_controller.sv
// Lane route controller: clears, configures and fills a bank of data lanes,
// then streams their MISO FIFOs in lockstep with optional tile replay.
module lane_route_controller #(
  parameter int NUM_LANES  = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                            i_clk,
  input  logic                            i_nrst,
  input  logic                            i_start,
  input  logic [ADDR_WIDTH-1:0]           i_base_addr,
  input  logic [ADDR_WIDTH-1:0]           i_lane_stride,
  input  logic [ADDR_WIDTH-1:0]           i_first_word,
  input  logic [ADDR_WIDTH-1:0]           i_word_limit,
  input  logic [CNT_WIDTH-1:0]            i_reuse,
  input  logic                            i_pop_ready,
  input  logic [NUM_LANES-1:0]            i_lane_route_done,
  input  logic [NUM_LANES-1:0]            i_lane_miso_full,
  output logic                            o_reg_clear,
  output logic                            o_addr_write_en,
  output logic [NUM_LANES*ADDR_WIDTH-1:0] o_lane_start_addr,
  output logic [NUM_LANES*ADDR_WIDTH-1:0] o_lane_end_addr,
  output logic                            o_spad_rd_en,
  output logic [ADDR_WIDTH-1:0]           o_spad_addr,
  output logic [ADDR_WIDTH-1:0]           o_lane_addr,
  output logic                            o_data_valid,
  output logic                            o_ac_en,
  output logic                            o_miso_pop_en,
  output logic                            o_fifo_ptr_reset,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_CONFIG = 3'd2;
  localparam logic [2:0] S_ROUTE  = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;
  localparam logic [2:0] S_STREAM = 3'd5;
  localparam logic [2:0] S_REWIND = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]            state;
  logic [2:0]            state_nx;
  logic [ADDR_WIDTH-1:0] cfg_base;
  logic [ADDR_WIDTH-1:0] cfg_stride;
  logic [ADDR_WIDTH-1:0] cfg_limit;
  logic [CNT_WIDTH-1:0]  cfg_reuse;
  logic [ADDR_WIDTH-1:0] spad_addr;
  logic [ADDR_WIDTH-1:0] lane_addr_q;
  logic                  dv_q;
  logic                  err_q;
  logic [CNT_WIDTH-1:0]  pop_cnt;
  logic [CNT_WIDTH-1:0]  pop_nxt;
  logic [CNT_WIDTH-1:0]  rep_cnt;
  logic [CNT_WIDTH-1:0]  stride_c;

  logic st_idle;
  logic st_route;
  logic st_flush;
  logic st_stream;
  logic st_rewind;
  logic start_ok;
  logic all_done;
  logic ovf;
  logic at_limit;
  logic pop_left;
  logic pop;
  logic last_pop;
  logic str_end;
  logic more_reps;
  logic set_err;

  assign st_idle   = (state == S_IDLE);
  assign st_route  = (state == S_ROUTE);
  assign st_flush  = (state == S_FLUSH);
  assign st_stream = (state == S_STREAM);
  assign st_rewind = (state == S_REWIND);

  assign start_ok  = st_idle && i_start;
  assign all_done  = &i_lane_route_done;
  assign ovf       = (st_route || st_flush) && dv_q
                   && (|i_lane_miso_full);
  assign at_limit  = (spad_addr >= cfg_limit);

  assign stride_c  = CNT_WIDTH'(cfg_stride);
  assign pop_left  = (pop_cnt != stride_c);
  assign pop       = st_stream && i_pop_ready && pop_left;
  assign pop_nxt   = pop_cnt + CNT_WIDTH'(1);
  assign last_pop  = pop && (pop_nxt == stride_c);
  assign str_end   = !pop_left || last_pop;
  assign more_reps = (rep_cnt < cfg_reuse);

  assign set_err   = ovf || (st_route && !all_done && at_limit);

  // Next-state selection for the fill / stream sequence.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (i_start) state_nx = S_CLEAR;
      S_CLEAR:  state_nx = S_CONFIG;
      S_CONFIG: state_nx = S_ROUTE;
      S_ROUTE: begin
        if (ovf)           state_nx = S_DONE;
        else if (all_done) state_nx = S_FLUSH;
        else if (at_limit) state_nx = S_DONE;
      end
      S_FLUSH:  state_nx = ovf ? S_DONE : S_STREAM;
      S_STREAM: begin
        if (str_end)
          state_nx = more_reps ? S_REWIND : S_DONE;
      end
      S_REWIND: state_nx = S_STREAM;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Tile configuration captured on an accepted start.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      cfg_base   <= '0;
      cfg_stride <= '0;
      cfg_limit  <= '0;
      cfg_reuse  <= '0;
    end else if (start_ok) begin
      cfg_base   <= i_base_addr;
      cfg_stride <= i_lane_stride;
      cfg_limit  <= i_word_limit;
      cfg_reuse  <= i_reuse;
    end
  end

  // Scratchpad word address walks forward once per ROUTE cycle.
  always_ff @(posedge i_clk) begin
    if (!i_nrst)       spad_addr <= '0;
    else if (start_ok) spad_addr <= i_first_word;
    else if (st_route) spad_addr <= spad_addr + ADDR_WIDTH'(1);
  end

  // Align address and valid with the one-cycle scratchpad read latency.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      lane_addr_q <= '0;
      dv_q        <= 1'b0;
    end else begin
      lane_addr_q <= spad_addr;
      dv_q        <= st_route;
    end
  end

  // Pop and replay counters for the stream phase.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      pop_cnt <= '0;
      rep_cnt <= '0;
    end else if (start_ok) begin
      pop_cnt <= '0;
      rep_cnt <= '0;
    end else if (st_rewind) begin
      pop_cnt <= '0;
      rep_cnt <= rep_cnt + CNT_WIDTH'(1);
    end else if (pop) begin
      pop_cnt <= pop_nxt;
    end
  end

  // Sticky error, cleared only by the next accepted start.
  always_ff @(posedge i_clk) begin
    if (!i_nrst)       err_q <= 1'b0;
    else if (start_ok) err_q <= 1'b0;
    else if (set_err)  err_q <= 1'b1;
  end

  // Lane windows as a running sum of the stride from the base address.
  always_comb begin
    logic [ADDR_WIDTH-1:0] acc;
    o_lane_start_addr = '0;
    o_lane_end_addr   = '0;
    acc               = cfg_base;
    for (int k = 0; k < NUM_LANES; k++) begin
      o_lane_start_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = acc;
      acc = acc + cfg_stride;
      o_lane_end_addr[k*ADDR_WIDTH +: ADDR_WIDTH]   = acc;
    end
  end

  assign o_reg_clear      = (state == S_CLEAR);
  assign o_addr_write_en  = (state == S_CONFIG);
  assign o_spad_rd_en     = st_route;
  assign o_spad_addr      = spad_addr;
  assign o_lane_addr      = lane_addr_q;
  assign o_data_valid     = dv_q;
  assign o_ac_en          = st_route || st_flush;
  assign o_miso_pop_en    = pop;
  assign o_fifo_ptr_reset = st_rewind;
  assign o_busy           = !st_idle;
  assign o_done           = (state == S_DONE);
  assign o_error          = err_q;

endmodule

// File: tb/tb_lane_route_controller.sv
// Directed bench for lane_route_controller: fill, stream, replay,
// backpressure, error paths and mid-stream reset.
module tb_lane_route_controller;

  localparam int NL = 4;
  localparam int AW = 8;
  localparam int CW = 8;

  logic            i_clk;
  logic            i_nrst;
  logic            i_start;
  logic [AW-1:0]   i_base_addr;
  logic [AW-1:0]   i_lane_stride;
  logic [AW-1:0]   i_first_word;
  logic [AW-1:0]   i_word_limit;
  logic [CW-1:0]   i_reuse;
  logic            i_pop_ready;
  logic [NL-1:0]   i_lane_route_done;
  logic [NL-1:0]   i_lane_miso_full;
  logic            o_reg_clear;
  logic            o_addr_write_en;
  logic [NL*AW-1:0] o_lane_start_addr;
  logic [NL*AW-1:0] o_lane_end_addr;
  logic            o_spad_rd_en;
  logic [AW-1:0]   o_spad_addr;
  logic [AW-1:0]   o_lane_addr;
  logic            o_data_valid;
  logic            o_ac_en;
  logic            o_miso_pop_en;
  logic            o_fifo_ptr_reset;
  logic            o_busy;
  logic            o_done;
  logic            o_error;

  lane_route_controller #(
    .NUM_LANES (NL),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW)
  ) dut (
    .i_clk            (i_clk),
    .i_nrst           (i_nrst),
    .i_start          (i_start),
    .i_base_addr      (i_base_addr),
    .i_lane_stride    (i_lane_stride),
    .i_first_word     (i_first_word),
    .i_word_limit     (i_word_limit),
    .i_reuse          (i_reuse),
    .i_pop_ready      (i_pop_ready),
    .i_lane_route_done(i_lane_route_done),
    .i_lane_miso_full (i_lane_miso_full),
    .o_reg_clear      (o_reg_clear),
    .o_addr_write_en  (o_addr_write_en),
    .o_lane_start_addr(o_lane_start_addr),
    .o_lane_end_addr  (o_lane_end_addr),
    .o_spad_rd_en     (o_spad_rd_en),
    .o_spad_addr      (o_spad_addr),
    .o_lane_addr      (o_lane_addr),
    .o_data_valid     (o_data_valid),
    .o_ac_en          (o_ac_en),
    .o_miso_pop_en    (o_miso_pop_en),
    .o_fifo_ptr_reset (o_fifo_ptr_reset),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_error          (o_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_asrt = 0;
  int n_fail = 0;

  int        done_at;
  logic [3:0] full_mask;
  bit        toggle;

  int c_clear, n_clear, c_cfg, n_cfg;
  int n_reads, first_rd, last_rd;
  int n_pops, n_bad_pop, n_rew, n_ac, n_align;
  int grp [4];
  int c_done, n_done;
  logic err_done, err_clear;
  logic [NL*AW-1:0] st_v, en_v;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input int budget);
    logic prv_rd;
    logic [AW-1:0] prv_addr;
    c_clear = -1; n_clear = 0; c_cfg = -1; n_cfg = 0;
    n_reads = 0; first_rd = -1; last_rd = -1;
    n_pops = 0; n_bad_pop = 0; n_rew = 0; n_ac = 0; n_align = 0;
    for (int g = 0; g < 4; g++) grp[g] = 0;
    c_done = -1; n_done = 0; err_done = 1'bx; err_clear = 1'bx;
    st_v = '0; en_v = '0;
    i_lane_route_done = '0;
    i_lane_miso_full  = '0;
    i_pop_ready       = 1'b0;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start  = 1'b0;
    prv_rd   = 1'b0;
    prv_addr = o_spad_addr;
    for (int c = 1; c <= budget; c++) begin
      if (o_spad_rd_en && int'(o_spad_addr) >= done_at)
        i_lane_route_done = '1;
      i_lane_miso_full = o_data_valid ? full_mask : '0;
      i_pop_ready = toggle ? c[0] : 1'b1;
      #1;
      if (o_reg_clear) begin
        n_clear++; c_clear = c; err_clear = o_error;
      end
      if (o_addr_write_en) begin
        n_cfg++; c_cfg = c;
        st_v = o_lane_start_addr; en_v = o_lane_end_addr;
      end
      if (o_spad_rd_en) begin
        if (n_reads == 0) first_rd = int'(o_spad_addr);
        last_rd = int'(o_spad_addr);
        n_reads++;
      end
      if (o_data_valid !== prv_rd) n_align++;
      else if (o_data_valid && o_lane_addr !== prv_addr) n_align++;
      if (o_ac_en) n_ac++;
      if (o_miso_pop_en) begin
        n_pops++;
        if (!i_pop_ready) n_bad_pop++;
        if (n_rew < 4) grp[n_rew]++;
      end
      if (o_fifo_ptr_reset) n_rew++;
      prv_rd   = o_spad_rd_en;
      prv_addr = o_spad_addr;
      if (o_done) begin
        n_done++; c_done = c; err_done = o_error;
        break;
      end
      @(posedge i_clk); #1;
    end
    chk("done_seen", n_done, 1);
    @(posedge i_clk); #1;
    chk("idle_after_done", {o_busy, o_done}, 2'b00);
  endtask

  initial begin
    int pc;
    int nd;
    i_nrst = 1'b0; i_start = 1'b0;
    i_base_addr = '0; i_lane_stride = '0; i_first_word = '0;
    i_word_limit = '0; i_reuse = '0; i_pop_ready = 1'b0;
    i_lane_route_done = '0; i_lane_miso_full = '0;
    done_at = 999; full_mask = '0; toggle = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_outs", |{o_reg_clear, o_addr_write_en, o_lane_start_addr,
        o_lane_end_addr, o_spad_rd_en, o_spad_addr, o_lane_addr,
        o_data_valid, o_ac_en, o_miso_pop_en, o_fifo_ptr_reset,
        o_busy, o_done, o_error}, 1'b0);
    i_nrst = 1'b1;
    @(posedge i_clk); #1;

    // basic fill / stream
    i_base_addr = 8'd0; i_lane_stride = 8'd8; i_first_word = 8'd0;
    i_word_limit = 8'd255; i_reuse = '0;
    done_at = 4; full_mask = '0; toggle = 1'b0;
    run_op(60);
    chk("b_clear_cyc", c_clear, 1);
    chk("b_n_clear", n_clear, 1);
    chk("b_cfg_cyc", c_cfg, 2);
    chk("b_n_cfg", n_cfg, 1);
    chk("b_first_rd", first_rd, 0);
    chk("b_last_rd", last_rd, 4);
    chk("b_n_reads", n_reads, 5);
    chk("b_align", n_align, 0);
    chk("b_ac_cycles", n_ac, 6);
    chk("b_pops", n_pops, 8);
    chk("b_done_cyc", c_done, 17);
    chk("b_error", err_done, 1'b0);
    chk("b_start", st_v, 32'h1810_0800);
    chk("b_end", en_v, 32'h2018_1008);

    // address outputs
    i_base_addr = 8'd5; i_lane_stride = 8'd3; done_at = 0;
    run_op(60);
    chk("a_start", st_v, 32'h0E0B_0805);
    chk("a_end", en_v, 32'h110E_0B08);
    chk("a_pops", n_pops, 3);
    chk("a_hold_start", o_lane_start_addr, 32'h0E0B_0805);

    // address wrap modulo 2^ADDR_WIDTH
    i_base_addr = 8'd250; i_lane_stride = 8'd3;
    run_op(60);
    chk("w_start", st_v, 32'h0300_FDFA);
    chk("w_end", en_v, 32'h0603_00FD);

    // backpressure
    i_base_addr = 8'd0; i_lane_stride = 8'd8; done_at = 4; toggle = 1'b1;
    run_op(80);
    chk("bp_pops", n_pops, 8);
    chk("bp_bad_pop", n_bad_pop, 0);
    chk("bp_done_cyc", c_done, 24);
    toggle = 1'b0;

    // reuse
    i_lane_stride = 8'd4; i_reuse = 8'd2;
    run_op(80);
    chk("r_pops", n_pops, 12);
    chk("r_rewinds", n_rew, 2);
    chk("r_grp0", grp[0], 4);
    chk("r_grp1", grp[1], 4);
    chk("r_grp2", grp[2], 4);
    chk("r_done_cyc", c_done, 23);
    i_reuse = '0;

    // zero stride
    i_lane_stride = 8'd0; done_at = 0;
    run_op(40);
    chk("z_pops", n_pops, 0);
    chk("z_done_cyc", c_done, 6);
    chk("z_start", st_v, 32'h0);

    // overflow on lane 2
    i_lane_stride = 8'd8; done_at = 999; full_mask = 4'b0100;
    run_op(40);
    chk("o_error", err_done, 1'b1);
    chk("o_pops", n_pops, 0);
    chk("o_done_cyc", c_done, 5);
    chk("o_sticky", o_error, 1'b1);
    full_mask = '0;

    // word limit timeout
    i_word_limit = 8'd2;
    run_op(40);
    chk("l_error", err_done, 1'b1);
    chk("l_n_reads", n_reads, 3);
    chk("l_last_rd", last_rd, 2);
    chk("l_done_cyc", c_done, 6);
    i_word_limit = 8'd255;

    // error clears on next start
    done_at = 4;
    run_op(60);
    chk("c_err_clear", err_clear, 1'b0);
    chk("c_error", err_done, 1'b0);
    chk("c_pops", n_pops, 8);

    // reset mid-STREAM
    i_lane_route_done = '0; i_pop_ready = 1'b1;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    pc = 0;
    for (int c = 1; c <= 40 && pc < 3; c++) begin
      if (o_spad_rd_en && int'(o_spad_addr) >= 4) i_lane_route_done = '1;
      #1;
      if (o_miso_pop_en) pc++;
      @(posedge i_clk); #1;
    end
    chk("m_reach_stream", pc, 3);
    i_nrst = 1'b0;
    @(posedge i_clk); #1;
    i_nrst = 1'b1;
    chk("m_outs_zero", |{o_reg_clear, o_addr_write_en, o_lane_start_addr,
        o_lane_end_addr, o_spad_rd_en, o_spad_addr, o_lane_addr,
        o_data_valid, o_ac_en, o_miso_pop_en, o_fifo_ptr_reset,
        o_busy, o_done, o_error}, 1'b0);
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      if (o_done || o_busy) nd++;
      @(posedge i_clk); #1;
    end
    chk("m_no_done", nd, 0);
    run_op(60);
    chk("m_rerun_pops", n_pops, 8);
    chk("m_rerun_done", c_done, 17);
    chk("m_rerun_start", st_v, 32'h1810_0800);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
